// File: rtl/griffin_round_sched.sv
// griffin_round_sched: Griffin permutation round scheduler; define GRIFFIN_SCHED_ABORT_EN to add the abort input
module griffin_round_sched #(
  parameter int N_BITS     = 254,
  parameter int STATE_SIZE = 3,
  parameter int NUM_ROUNDS = 12,
  parameter int RC_ADDR_W  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
`ifdef GRIFFIN_SCHED_ABORT_EN
  input  logic                                  abort,
`endif
  output logic                                  busy,
  output logic                                  done,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]     in_state,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]     out_state,
  output logic                                  rc_rd_en,
  output logic [RC_ADDR_W-1:0]                  rc_addr,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]     rc_data,
  output logic                                  rnd_enable,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]     rnd_state_in,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]     rnd_rc,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]     rnd_state_out,
  input  logic                                  rnd_done
);
  typedef enum logic [2:0] {IDLE, LOAD_RC, WAIT_RC, FIRE, WAIT, NEXT, FINISH} state_t;
  localparam logic [RC_ADDR_W-1:0] LAST = RC_ADDR_W'(NUM_ROUNDS - 1);
  state_t                              state_q, state_d;
  logic [RC_ADDR_W-1:0]                cnt_q, cnt_d;
  logic [STATE_SIZE-1:0][N_BITS-1:0]   work_q, work_d, rc_q, rc_d, out_q, out_d;
  logic                                abort_w;
`ifdef GRIFFIN_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif
  assign busy         = state_q != IDLE;
  assign done         = state_q == FINISH;
  assign rc_rd_en     = state_q == LOAD_RC;
  assign rc_addr      = rc_rd_en ? cnt_q : '0;
  assign rnd_enable   = state_q == FIRE;
  assign rnd_state_in = work_q;
  assign rnd_rc       = rc_q;
  assign out_state    = out_q;
  // next-state: sequence one round per LOAD_RC..NEXT pass; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    rc_d    = rc_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_RC;
          work_d  = in_state;
          cnt_d   = '0;
        end
      end
      LOAD_RC: state_d = WAIT_RC;
      WAIT_RC: begin
        rc_d    = rc_data;
        state_d = FIRE;
      end
      FIRE:    state_d = WAIT;
      WAIT:    state_d = rnd_done ? NEXT : WAIT;
      NEXT: begin
        work_d = rnd_state_out;
        if (cnt_q == LAST) begin
          state_d = FINISH;
          out_d   = rnd_state_out;
        end else begin
          state_d = LOAD_RC;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_w && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      work_d  = work_q;
      rc_d    = rc_q;
      out_d   = out_q;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      rc_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      rc_q    <= rc_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_griffin_round_sched.sv
// tb_griffin_round_sched: randomized self-checking bench with stub round core and constant memory
module tb_griffin_round_sched;
  localparam int NB = 64, SS = 3, NR = 3, AW = 4;
  typedef logic [SS-1:0][NB-1:0] st_t;
  logic clk = 0, reset = 0, start = 0;
`ifdef GRIFFIN_SCHED_ABORT_EN
  logic abort = 0;
`endif
  st_t in_state = '0, out_state, rc_data, rnd_state_in, rnd_rc, rnd_state_out;
  logic busy, done, rc_rd_en, rnd_enable, rnd_done;
  logic [AW-1:0] rc_addr;
  int vectors = 0, errors = 0;
  int lat_l = 5, core_cnt = 0, cyc = 0;
  logic spur_en = 0;
  st_t rc_mem [16];
  int r_lat, r_en, r_done;
  bit r_addr_ok, r_rc_ok, r_stab_ok;

  griffin_round_sched #(.N_BITS(NB), .STATE_SIZE(SS), .NUM_ROUNDS(NR), .RC_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef GRIFFIN_SCHED_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .in_state(in_state), .out_state(out_state),
    .rc_rd_en(rc_rd_en), .rc_addr(rc_addr), .rc_data(rc_data),
    .rnd_enable(rnd_enable), .rnd_state_in(rnd_state_in), .rnd_rc(rnd_rc),
    .rnd_state_out(rnd_state_out), .rnd_done(rnd_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // stub core: done lat_l cycles after enable; constant memory: one-cycle read latency
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_cnt <= 0;
      rc_data  <= '0;
    end else begin
      if (rnd_enable) core_cnt <= lat_l;
      else if (core_cnt > 0) core_cnt <= core_cnt - 1;
      if (rc_rd_en) rc_data <= rc_mem[rc_addr];
    end
  end
  assign rnd_done = (core_cnt == 1) || (spur_en && rc_rd_en);
  always_comb begin
    for (int w = 0; w < SS; w++) rnd_state_out[w] = rnd_state_in[w] + 1;
  end

  function automatic st_t add_k(input st_t s, input int k);
    for (int w = 0; w < SS; w++) s[w] = s[w] + NB'(k);
    return s;
  endfunction
  function automatic int model_lat(input int l);
    return NR * (l + 4) + 1;
  endfunction
  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < SS; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic run_perm(input st_t s, input int l, input bit pulse);
    int t0, c, n_addr;
    bit in_round;
    st_t snap_s, snap_r;
    lat_l = l;
    @(negedge clk);
    in_state = s;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    t0 = cyc;
    r_lat = -1; r_en = 0; r_done = 0;
    r_addr_ok = 1; r_rc_ok = 1; r_stab_ok = 1;
    n_addr = 0; in_round = 0;
    for (int i = 0; i < model_lat(l) + 30; i++) begin
      @(negedge clk);
      c = cyc - t0 + 1;
      if (pulse) start = (c == 3 || c == 10);
      if (rc_rd_en) begin
        if (rc_addr != AW'(n_addr)) r_addr_ok = 0;
        n_addr++;
        in_round = 0;
      end else if (rc_addr != '0) r_addr_ok = 0;
      if (done) begin
        in_round = 0;
        r_done++;
        if (r_lat < 0) r_lat = c;
      end
      if (rnd_enable) begin
        if (r_en > 15 || rnd_rc !== rc_mem[r_en] || rnd_state_in !== add_k(s, r_en)) r_rc_ok = 0;
        snap_s = rnd_state_in;
        snap_r = rnd_rc;
        in_round = 1;
        r_en++;
      end else if (in_round && (rnd_state_in !== snap_s || rnd_rc !== snap_r)) r_stab_ok = 0;
    end
    start = 0;
    if (n_addr != NR) r_addr_ok = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1;
    #2;
    vectors++;
    if ({busy, done, rc_rd_en, rnd_enable} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {busy, done, rc_rd_en, rnd_enable});
    end
    vectors++;
    if (rc_addr !== '0 || out_state !== '0) begin
      errors++; $display("FAIL reset_addr_out got addr %0h out %h exp 0", rc_addr, out_state);
    end
    vectors++;
    if (rnd_state_in !== '0 || rnd_rc !== '0) begin
      errors++; $display("FAIL reset_rnd got %h / %h exp 0", rnd_state_in, rnd_rc);
    end
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    st_t s;
    for (int a = 0; a < 16; a++) for (int w = 0; w < SS; w++) rc_mem[a][w] = NB'(a);
    s[0] = 1; s[1] = 2; s[2] = 3;
    run_perm(s, 5, 0);
    vectors++;
    if (r_lat !== 28) begin errors++; $display("FAIL basic_latency got %0d exp 28", r_lat); end
    vectors++;
    if (out_state !== add_k(s, NR)) begin errors++; $display("FAIL basic_out got %h exp %h", out_state, add_k(s, NR)); end
    vectors++;
    if (!r_addr_ok) begin errors++; $display("FAIL basic_rc_addr got bad sequence exp 0,1,2"); end
    vectors++;
    if (r_en !== NR || r_done !== 1) begin errors++; $display("FAIL basic_counts got en %0d done %0d exp %0d 1", r_en, r_done, NR); end
    vectors++;
    if (!r_rc_ok || !r_stab_ok) begin errors++; $display("FAIL basic_round_inputs got rc_ok %0b stab_ok %0b exp 1 1", r_rc_ok, r_stab_ok); end
    vectors++;
    if (busy !== 1'b0 || out_state !== add_k(s, NR)) begin errors++; $display("FAIL basic_hold got busy %b out %h", busy, out_state); end
  endtask

  task automatic test_random();
    st_t s;
    int l;
    for (int a = 0; a < 16; a++) rc_mem[a] = rand_state();
    for (int k = 0; k < 5; k++) begin
      s = rand_state();
      l = $urandom_range(1, 7);
      run_perm(s, l, 0);
      vectors++;
      if (r_lat !== model_lat(l)) begin errors++; $display("FAIL rand_latency L=%0d got %0d exp %0d", l, r_lat, model_lat(l)); end
      vectors++;
      if (out_state !== add_k(s, NR)) begin errors++; $display("FAIL rand_out got %h exp %h", out_state, add_k(s, NR)); end
      vectors++;
      if (!r_addr_ok || !r_rc_ok || !r_stab_ok || r_done !== 1) begin
        errors++; $display("FAIL rand_round got addr %0b rc %0b stab %0b done %0d exp 1 1 1 1", r_addr_ok, r_rc_ok, r_stab_ok, r_done);
      end
    end
  endtask

  task automatic test_start_ignored();
    st_t s = rand_state();
    run_perm(s, 5, 1);
    vectors++;
    if (r_lat !== 28 || r_done !== 1) begin errors++; $display("FAIL start_busy got lat %0d dones %0d exp 28 1", r_lat, r_done); end
    vectors++;
    if (r_en !== NR || out_state !== add_k(s, NR)) begin errors++; $display("FAIL start_busy_en got en %0d out %h exp %0d", r_en, out_state, NR); end
  endtask

  task automatic test_spurious_done();
    st_t s = rand_state();
    spur_en = 1;
    run_perm(s, 5, 0);
    spur_en = 0;
    vectors++;
    if (r_lat !== 28 || out_state !== add_k(s, NR)) begin errors++; $display("FAIL spurious_done got lat %0d out %h exp 28 %h", r_lat, out_state, add_k(s, NR)); end
  endtask

  task automatic test_reset_mid();
    st_t s = rand_state();
    int n = 0, d = 0;
    lat_l = 5;
    @(negedge clk);
    in_state = s;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 60 && n < 2; i++) begin
      @(negedge clk);
      if (rnd_enable) n++;
    end
    vectors++;
    if (n !== 2) begin errors++; $display("FAIL reset_mid_reach got fires %0d exp 2", n); end
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    vectors++;
    if ({busy, done, rc_rd_en, rnd_enable} !== 4'b0 || rc_addr !== '0) begin
      errors++; $display("FAIL reset_mid_ctrl got %b addr %0h exp 0", {busy, done, rc_rd_en, rnd_enable}, rc_addr);
    end
    vectors++;
    if (out_state !== '0 || rnd_state_in !== '0 || rnd_rc !== '0) begin
      errors++; $display("FAIL reset_mid_data got %h %h %h exp 0", out_state, rnd_state_in, rnd_rc);
    end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) d++;
    end
    vectors++;
    if (d !== 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", d); end
    run_perm(s, 5, 0);
    vectors++;
    if (r_lat !== 28 || out_state !== add_k(s, NR)) begin errors++; $display("FAIL reset_mid_restart got lat %0d out %h exp 28 %h", r_lat, out_state, add_k(s, NR)); end
  endtask

  task automatic test_back_to_back();
    st_t s = rand_state();
    int dc [$];
    int low = 0, runs = 0, bad = 0;
    lat_l = 1;
    @(negedge clk);
    in_state = s;
    start = 1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) dc.push_back(cyc);
      if (dc.size() > 0) begin
        if (!busy) low++;
        else if (low != 0) begin
          runs++;
          if (low != 1) bad++;
          low = 0;
        end
      end
    end
    start = 0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    vectors++;
    if (dc.size() < 3) begin errors++; $display("FAIL b2b_count got %0d dones exp >=3", dc.size()); end
    for (int k = 1; k < dc.size(); k++) begin
      vectors++;
      if (dc[k] - dc[k-1] !== 17) begin errors++; $display("FAIL b2b_period got %0d exp 17", dc[k] - dc[k-1]); end
    end
    vectors++;
    if (bad !== 0 || runs < 2) begin errors++; $display("FAIL b2b_idle_gap got bad %0d runs %0d exp 0 >=2", bad, runs); end
    vectors++;
    if (out_state !== add_k(s, NR)) begin errors++; $display("FAIL b2b_out got %h exp %h", out_state, add_k(s, NR)); end
  endtask

`ifdef GRIFFIN_SCHED_ABORT_EN
  task automatic test_abort();
    st_t s = rand_state(), s2 = rand_state();
    int n = 0, d = 0;
    run_perm(s, 2, 0);
    lat_l = 2;
    @(negedge clk);
    in_state = s2;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      if (rnd_enable) n++;
      if (n < 3) @(negedge clk);
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || out_state !== add_k(s, NR)) begin
      errors++; $display("FAIL abort got busy %b done %b out %h exp 0 0 %h", busy, done, out_state, add_k(s, NR));
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) d++;
    end
    vectors++;
    if (d !== 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles exp 0", d); end
    run_perm(s2, 2, 0);
    vectors++;
    if (r_lat !== model_lat(2) || out_state !== add_k(s2, NR) || !r_addr_ok) begin
      errors++; $display("FAIL abort_restart got lat %0d out %h exp %0d %h", r_lat, out_state, model_lat(2), add_k(s2, NR));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_start_ignored();
    test_spurious_done();
    test_reset_mid();
    test_back_to_back();
`ifdef GRIFFIN_SCHED_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/griffin_round_sched.md
GRIFFIN_ROUND_SCHED -- requirements
Module: griffin_round_sched

Interface
REQ-001 SHALL have parameter N_BITS, default 254, field element width.
REQ-002 SHALL have parameter STATE_SIZE, default 3, state words per permutation.
REQ-003 SHALL have parameter NUM_ROUNDS, default 12, rounds per permutation (>=1).
REQ-004 SHALL have parameter RC_ADDR_W, default 4, constant-memory address width (2**RC_ADDR_W >= NUM_ROUNDS).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports start input 1 (begin permutation), busy output 1, done output 1 (one-cycle completion pulse).
REQ-008 SHALL have ports in_state input [STATE_SIZE] x N_BITS and out_state output [STATE_SIZE] x N_BITS.
REQ-009 SHALL have ports rc_rd_en output 1, rc_addr output RC_ADDR_W, rc_data input [STATE_SIZE] x N_BITS; rc_data is valid the cycle after rc_rd_en.
REQ-010 SHALL have ports rnd_enable output 1, rnd_state_in output [STATE_SIZE] x N_BITS, rnd_rc output [STATE_SIZE] x N_BITS, rnd_state_out input [STATE_SIZE] x N_BITS, rnd_done input 1; these drive one round core.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD_RC -> WAIT_RC -> FIRE -> WAIT -> NEXT -> (LOAD_RC | FINISH) -> IDLE.
REQ-012 IDLE: start=1 SHALL capture in_state into the working register and set round counter to 0; start=0 stays IDLE.
REQ-013 LOAD_RC: rc_rd_en=1 and rc_addr=round counter for exactly one cycle.
REQ-014 WAIT_RC: SHALL capture rc_data into rnd_rc register.
REQ-015 FIRE: rnd_enable=1 for exactly one cycle; rnd_state_in=working register.
REQ-016 rnd_state_in and rnd_rc SHALL be held stable from FIRE until NEXT is left.
REQ-017 WAIT: SHALL remain until rnd_done=1 sampled; rnd_done outside WAIT SHALL be ignored.
REQ-018 NEXT: SHALL load rnd_state_out into working register; if counter==NUM_ROUNDS-1 go FINISH, else increment counter and go LOAD_RC.
REQ-019 FINISH: done=1 for one cycle; out_state SHALL be updated with final working register in the same cycle and held until the next FINISH.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start while busy=1 SHALL be ignored with no side effects.
REQ-022 Latency: with L = cycles spent in WAIT (>=1), done SHALL be high exactly NUM_ROUNDS*(L+4)+1 cycles after the start-sampling edge.
REQ-023 start in the FINISH cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted (back-to-back throughput).
REQ-024 Round counter SHALL never exceed NUM_ROUNDS-1; rc_addr SHALL be zero when rc_rd_en=0.

Reset
REQ-025 reset=1 SHALL asynchronously force IDLE, round counter 0, and busy, done, rc_rd_en, rnd_enable to 0, rc_addr to 0, out_state, rnd_state_in, rnd_rc to 0.
REQ-026 reset mid-permutation SHALL abandon it; no done pulse SHALL follow until a new start is accepted.

Configuration
REQ-027 Macro GRIFFIN_SCHED_ABORT_EN defined: input port abort (1 bit) SHALL exist; abort=1 in any non-IDLE state SHALL return FSM to IDLE on the next edge with no done pulse, out_state unchanged, round counter 0.
REQ-028 Macro GRIFFIN_SCHED_ABORT_EN undefined: abort port SHALL not exist; behaviour per REQ-011..REQ-024 only.

Verification
REQ-029 NUM_ROUNDS=3, stub core (each word +1, rnd_done 5 cycles after rnd_enable so L=5), in_state={1,2,3}, rc_data=addr -> done at cycle 28, out_state={4,5,6}, rc_addr sequence 0,1,2.
REQ-030 Same setup, start pulsed at cycles 3 and 10 during run -> ignored, single done at cycle 28, rnd_enable asserted exactly 3 times.
REQ-031 reset asserted during round 1 WAIT -> all outputs 0 same cycle asynchronously, no done; fresh start -> correct result at cycle 28 after it.
REQ-032 Stub core pulsing rnd_done while FSM in LOAD_RC -> ignored, FSM still waits full L in WAIT.
REQ-033 start held high continuously, NUM_ROUNDS=3, L=1 -> done pulses every 17 cycles, busy low exactly one cycle between runs.
REQ-034 With GRIFFIN_SCHED_ABORT_EN: abort in round 2 FIRE -> IDLE next edge, busy=0, no done, out_state keeps previous value.
